// File: rtl/leds_controller.sv
// Four-LED PWM driver with a linear soft fade on enable/disable; pattern and fade level change only at PWM period wraps.
// Optional LEDS_BLINK_EN adds ctrl_blink and a periodic all-off blink phase.
module leds_controller #(
`ifdef LEDS_BLINK_EN
    parameter int unsigned BLINK_PERIODS = 64,
`endif
    parameter int unsigned PWM_BITS   = 8,
    parameter int unsigned DUTY       = 128,
    parameter int unsigned RAMP_STEP  = 8,
    parameter bit          ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
`ifdef LEDS_BLINK_EN
    input  logic       ctrl_blink,
`endif
    input  logic       ctrl_en,
    input  logic       ctrl_led0,
    input  logic       ctrl_led1,
    input  logic       ctrl_led2,
    input  logic       ctrl_led3,
    output logic [3:0] led_out,
    output logic       busy
);
    localparam logic [PWM_BITS:0] DUTY_L = DUTY[PWM_BITS:0];
    localparam logic [PWM_BITS:0] STEP_L = RAMP_STEP[PWM_BITS:0];
    localparam logic [3:0]        ALL_OFF = ACTIVE_LOW ? 4'hF : 4'h0;

    logic [PWM_BITS-1:0] cnt_q, cnt_d;
    logic [PWM_BITS:0]   level_q, level_d, target_d;
    logic [3:0]          shadow_q, shadow_d, lit_d, led_q, led_d;
    logic                busy_q, busy_d, wrap;

`ifdef LEDS_BLINK_EN
    localparam int BC_W = (BLINK_PERIODS > 1) ? $clog2(BLINK_PERIODS) : 1;
    logic [BC_W-1:0] bcnt_q, bcnt_d;
    logic            phase_q, phase_d, bsh_q, bsh_d;
`endif

    assign wrap = &cnt_q;

    always_comb begin
        cnt_d    = cnt_q + 1'b1;
        shadow_d = shadow_q;
        level_d  = level_q;
        busy_d   = busy_q;
        target_d = ctrl_en ? DUTY_L : '0;
        if (wrap) begin
            shadow_d = {ctrl_led3, ctrl_led2, ctrl_led1, ctrl_led0};
            // Saturating step toward target; differences compared first so nothing wraps.
            if (level_q < target_d)
                level_d = (target_d - level_q > STEP_L) ? level_q + STEP_L : target_d;
            else if (level_q > target_d)
                level_d = (level_q - target_d > STEP_L) ? level_q - STEP_L : target_d;
            busy_d = (level_d != target_d);
        end
        for (int i = 0; i < 4; i++)
            lit_d[i] = shadow_d[i] && ({1'b0, cnt_d} < level_d);
`ifdef LEDS_BLINK_EN
        bcnt_d  = bcnt_q;
        phase_d = phase_q;
        bsh_d   = bsh_q;
        if (wrap) begin
            bsh_d = ctrl_blink;
            if (bcnt_q == BC_W'(BLINK_PERIODS - 1)) begin
                bcnt_d  = '0;
                phase_d = ~phase_q;
            end else begin
                bcnt_d = bcnt_q + 1'b1;
            end
        end
        if (bsh_d && phase_d)
            lit_d = 4'h0;
`endif
        led_d = ACTIVE_LOW ? ~lit_d : lit_d;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q    <= '0;
            level_q  <= '0;
            shadow_q <= '0;
            busy_q   <= 1'b0;
            led_q    <= ALL_OFF;
`ifdef LEDS_BLINK_EN
            bcnt_q   <= '0;
            phase_q  <= 1'b0;
            bsh_q    <= 1'b0;
`endif
        end else begin
            cnt_q    <= cnt_d;
            level_q  <= level_d;
            shadow_q <= shadow_d;
            busy_q   <= busy_d;
            led_q    <= led_d;
`ifdef LEDS_BLINK_EN
            bcnt_q   <= bcnt_d;
            phase_q  <= phase_d;
            bsh_q    <= bsh_d;
`endif
        end
    end

    assign led_out = led_q;
    assign busy    = busy_q;
endmodule

// File: tb/tb_leds_controller.sv
// Bench for leds_controller: directed fade/pattern scenarios with literal expectations, then random stimulus
// checked every cycle against a period-level behavioural model.
module tb_leds_controller;
    localparam int PB   = 4;
    localparam int P    = 1 << PB;
    localparam int DUTY = 8;
    localparam int STEP = 4;
    localparam int BP   = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic ctrl_en = 1'b0, ctrl_led0 = 1'b0, ctrl_led1 = 1'b0, ctrl_led2 = 1'b0, ctrl_led3 = 1'b0;
    logic ctrl_blink = 1'b0;
    logic [3:0] led_out;
    logic busy;

    int checks = 0;
    int errors = 0;

    leds_controller #(
`ifdef LEDS_BLINK_EN
        .BLINK_PERIODS(BP),
`endif
        .PWM_BITS(PB), .DUTY(DUTY), .RAMP_STEP(STEP), .ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk), .rst(rst),
`ifdef LEDS_BLINK_EN
        .ctrl_blink(ctrl_blink),
`endif
        .ctrl_en(ctrl_en), .ctrl_led0(ctrl_led0), .ctrl_led1(ctrl_led1),
        .ctrl_led2(ctrl_led2), .ctrl_led3(ctrl_led3),
        .led_out(led_out), .busy(busy)
    );

    always #5 clk = ~clk;

    // Model state: position in the period, fade level, latched pattern, blink bookkeeping.
    int   m_pos = 0, m_level = 0, m_target = 0, m_bcnt = 0;
    bit   m_phase = 0, m_bsh = 0, m_busy = 0, m_valid = 0;
    bit [3:0] m_shadow = 0;

    function automatic logic [3:0] model_led();
        logic [3:0] lit;
        for (int i = 0; i < 4; i++) lit[i] = m_shadow[i] && (m_pos < m_level);
`ifdef LEDS_BLINK_EN
        if (m_bsh && m_phase) lit = 4'h0;
`endif
        return ~lit;
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            if (!rst) begin
                m_valid = 1; m_pos = 0; m_level = 0; m_shadow = 0; m_busy = 0;
                m_bcnt = 0; m_phase = 0; m_bsh = 0;
            end else if (m_valid) begin
                if (m_pos == P - 1) begin
                    m_shadow = {ctrl_led3, ctrl_led2, ctrl_led1, ctrl_led0};
                    m_target = ctrl_en ? DUTY : 0;
                    if (m_level < m_target) m_level = (m_level + STEP > m_target) ? m_target : m_level + STEP;
                    else if (m_level > m_target) m_level = (m_level - STEP < m_target) ? m_target : m_level - STEP;
                    m_busy = (m_level != m_target);
                    m_bsh = ctrl_blink;
                    if (m_bcnt == BP - 1) begin m_bcnt = 0; m_phase = !m_phase; end
                    else m_bcnt++;
                end
                m_pos = (m_pos + 1) % P;
            end
            #1;
            if (m_valid) begin
                checks++;
                if (led_out !== model_led() || busy !== m_busy) begin
                    errors++;
                    $display("FAIL cycle_model t=%0t led_out=%h busy=%b required led_out=%h busy=%b",
                             $time, led_out, busy, model_led(), m_busy);
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Wait for a negedge just after a period wrap, then observe one whole period.
    task automatic period(input string name, input int exp_lit0, input int exp_lit2, input int exp_busy);
        int guard = 0;
        int lit0 = 0, lit2 = 0, b;
        while (m_pos != 0 && guard < 2 * P) begin @(negedge clk); guard++; end
        chk({name, "_sync"}, int'(m_pos == 0), 1);
        b = busy;
        for (int k = 0; k < P; k++) begin
            lit0 += (led_out[0] == 1'b0);
            lit2 += (led_out[2] == 1'b0);
            @(negedge clk);
        end
        chk({name, "_lit0"}, lit0, exp_lit0);
        chk({name, "_lit2"}, lit2, exp_lit2);
        chk({name, "_busy"}, b, exp_busy);
    endtask

    initial begin
        int hold = 1;
        repeat (3) @(negedge clk);
        chk("reset_led", int'(led_out), 4'hF);
        chk("reset_busy", int'(busy), 0);
        rst = 1'b1;
        @(negedge clk);
        chk("after_release_pos", m_pos, 1);

        period("idle", 0, 0, 0);
        ctrl_en = 1; ctrl_led0 = 1;
        period("pre_on", 0, 0, 0);
        period("fade_in1", 4, 0, 1);
        period("steady", 8, 0, 0);

        repeat (5) @(negedge clk);
        ctrl_led2 = 1;
        for (int k = 5; k < P; k++) begin
            hold &= int'(led_out[2] == 1'b1);
            @(negedge clk);
        end
        chk("led2_midperiod_ignored", hold, 1);
        period("led2_on", 8, 8, 0);

        ctrl_en = 0;
        period("off_req", 8, 8, 0);
        period("fade_out1", 4, 4, 1);
        period("fade_out0", 0, 0, 0);

        ctrl_en = 1;
        period("re_en0", 0, 0, 0);
        period("re_en4", 4, 4, 1);
        period("re_en8", 8, 8, 0);
        ctrl_en = 0;
        period("rev_a", 8, 8, 0);
        ctrl_en = 1;
        period("rev_b", 4, 4, 1);
        period("rev_c", 8, 8, 0);
        chk("led3_dark", int'(led_out[3]), 1);

        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 199) != 0);
            if ($urandom_range(0, 19) == 0) ctrl_en    = ~ctrl_en;
            if ($urandom_range(0, 9) == 0)  ctrl_led0  = ~ctrl_led0;
            if ($urandom_range(0, 9) == 0)  ctrl_led1  = ~ctrl_led1;
            if ($urandom_range(0, 9) == 0)  ctrl_led2  = ~ctrl_led2;
            if ($urandom_range(0, 9) == 0)  ctrl_led3  = ~ctrl_led3;
            if ($urandom_range(0, 15) == 0) ctrl_blink = ~ctrl_blink;
        end
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/leds_controller.md
Name: leds_controller

Overview:
- Downstream stage of the LED bus interface. Consumes its ctrl_en and ctrl_led0..3 outputs and drives the four physical LED pins.
- Adds PWM dimming at a fixed duty and a linear soft fade on enable/disable.
- Latches the requested pattern only on PWM period boundaries, so a bus write mid-period never produces a runt pulse.

Parameters:
- PWM_BITS, 8: width of the free-running PWM counter; period = 2^PWM_BITS clk cycles.
- DUTY, 128: target lit cycles per period when enabled; range 0..2^PWM_BITS; width PWM_BITS+1.
- RAMP_STEP, 8: level change per period while fading; must be >= 1.
- ACTIVE_LOW, 1: 1 means a pin driven 0 lights its LED.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-low reset; sampled on posedge clk.
- ctrl_en  input  1  global enable from the LED bus interface.
- ctrl_led0..ctrl_led3  input  1 each  per-LED request from the LED bus interface.
- led_out  output  4  pin drive; bit i is LED i; polarity set by ACTIVE_LOW.
- busy  output  1  high while the fade level differs from its target.

Behaviour:
- Reset (rst==0 at posedge clk):
  - cnt=0, level=0, shadow pattern=0.
  - led_out = all-off: 4'hF if ACTIVE_LOW, else 4'h0.
  - busy=0.
- cnt: free-running, increments by 1 every cycle, wraps from 2^PWM_BITS-1 to 0.
- Boundary edge: the edge where cnt wraps to 0. On this edge only:
  - shadow <= {ctrl_led3..ctrl_led0} sampled at that edge.
  - target = ctrl_en ? DUTY : 0.
  - level moves toward target by RAMP_STEP and saturates at target (never overshoots; no wrap, no underflow below 0).
- Inputs are ignored between boundaries. A toggle that reverts before the next boundary has no visible effect.
- led_out:
  - Registered, computed from the next-state cnt, shadow and level.
  - LED i is lit in a cycle iff shadow[i]==1 and that cycle's cnt < level.
  - Each lit LED is therefore on for exactly `level` consecutive cycles at the start of each period, and is off for the rest.
  - level==0 gives fully off; level==2^PWM_BITS gives fully on, with no gap at the wrap.
- busy: registered; equals (level_next != target_next); updated on boundary edges only.
- Fade timing: steps of RAMP_STEP per period; the final step is partial when DUTY is not a multiple of RAMP_STEP.
- Direction reversal mid-fade: ctrl_en changes while busy. The new target applies at the next boundary, and level reverses direction from its current value. No jump.
- DUTY==0: LEDs are never lit; busy stays 0.
- Reset mid-fade: outputs go all-off on the next edge, and the fade restarts from level 0.

Optional Feature:
- Macro: LEDS_BLINK_EN.
- When defined:
  - Adds input ctrl_blink (1 bit), parameter BLINK_PERIODS (default 64), and an internal blink counter plus phase bit, all reset to 0.
  - Blink counter counts boundary edges; when it reaches BLINK_PERIODS-1 it clears and phase toggles.
  - ctrl_blink is sampled on boundaries into the shadow. While shadowed blink=1 and phase=1, all LEDs are forced off.
  - Fade level, cnt and busy are unaffected by blinking.
  - Blink counter and phase run continuously, whether or not blink is requested.
- When undefined: no ctrl_blink port, no blink logic; behaviour is exactly as in Behaviour.

Test Plan:
Bench setup: PWM_BITS=4, DUTY=8, RAMP_STEP=4, ACTIVE_LOW=1.
1. Hold rst=0 for 3 cycles, then release -> led_out=4'hF, busy=0, cnt starts at 0 on the first cycle after release.
2. ctrl_en=1, ctrl_led0=1 before a boundary:
   - First period: led_out[0]=0 for 4 cycles, then 1 for 12 cycles; busy=1.
   - Second period and later: led_out[0]=0 for 8 cycles, then 1 for 8; busy=0.
   - led_out[3:1] stay 1 throughout.
3. Set ctrl_led2=1 at cnt=5 mid-period -> led_out[2] stays 1 until the boundary, then follows the same 8/8 pattern as led_out[0].
4. From steady state (level 8), drop ctrl_en -> following periods show led0 lit for 4 cycles, then 0 cycles; busy goes 1 then returns to 0.
5. Re-raise ctrl_en one period into the fade-out -> level goes 4, then 8 (no drop to 0).
6. Build with LEDS_BLINK_EN, BLINK_PERIODS=2, ctrl_blink=1 at steady state -> led0 follows 8/8 PWM for 2 periods, then all-off for 2 periods, repeating.
